cache_set_nway: RTL and testbench
=================================

CACHE_SET_NWAY -- requirements
Module: cache_set_nway

Interface
REQ-001 SHALL have parameter BLOCK_BYTES, default 64, meaning bytes per line (power of 2, >= 4).
REQ-002 SHALL have parameter WAYS, default 4, meaning lines per set (power of 2, >= 2).
REQ-003 SHALL have parameter TAG_BITS, default 26, meaning stored tag width.
REQ-004 SHALL have parameter REFILL_W, default 64, meaning refill beat width in bits (32, 64 or 128; BLOCK_BYTES*8 >= REFILL_W); BEATS = BLOCK_BYTES*8/REFILL_W.
REQ-005 SHALL have parameter REPL_MODE, default 0, meaning victim policy (0 = true LRU ages, 1 = round-robin).
REQ-006 SHALL have port clk_i, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-007 SHALL have port reset_i, input, 1, meaning asynchronous active-high reset.
REQ-008 SHALL have port active_set_i, input, 1, meaning this set is addressed.
REQ-009 SHALL have port repl_grant_i, input, 1, meaning a refill beat is valid on rep_word_i this cycle.
REQ-010 SHALL have port invalidate_i, input, 1, meaning flush all lines.
REQ-011 SHALL have port block_i, input, $clog2(BLOCK_BYTES), meaning byte offset in line; bits [1:0] ignored.
REQ-012 SHALL have port tag_i, input, TAG_BITS, meaning lookup tag.
REQ-013 SHALL have port rep_word_i, input, REFILL_W, meaning refill beat data, beat n = line bits [n*REFILL_W +: REFILL_W].
REQ-014 SHALL have port data_o, output, 32, meaning word read from the hit way.
REQ-015 SHALL have port cache_set_miss_o, output, 1, meaning no valid tag match.
REQ-016 SHALL have port hit_way_o, output, $clog2(WAYS), meaning index of the hit way.
REQ-017 SHALL have port refill_busy_o, output, 1, meaning the FSM is in FILL.
REQ-018 SHALL have port refill_done_o, output, 1, meaning one-cycle pulse on the cycle after the final beat is written.

Function
REQ-019 SHALL compute hit combinationally as active_set_i AND valid[w] AND tag[w]==tag_i for some w; cache_set_miss_o = NOT hit, so an inactive set always reports a miss.
REQ-020 SHALL drive data_o with bytes [block_i[..:2]*4 +: 4] of the hit way, and data_o = 0 and hit_way_o = 0 on miss.
REQ-021 SHALL implement FSM states IDLE and FILL with a beat counter of width $clog2(BEATS)+1.
REQ-022 SHALL, in IDLE, when active_set_i & miss & repl_grant_i: select victim, capture tag_i, write beat 0 in the same cycle, and go to FILL with count 1 (or complete immediately if BEATS == 1).
REQ-023 SHALL select the victim as the lowest-index invalid way if any exists; otherwise the way with age WAYS-1 (REPL_MODE 0) or the round-robin pointer (REPL_MODE 1).
REQ-024 SHALL, in FILL, write beat[count] and increment count on each cycle with active_set_i & repl_grant_i, holding count unchanged otherwise (stall; no abort).
REQ-025 SHALL, on the cycle the beat BEATS-1 is written, set valid[victim], return to IDLE, and pulse refill_done_o on the next cycle, with the line hitting from that next cycle.
REQ-026 SHALL ignore tag_i changes during FILL, using only the captured tag.
REQ-027 SHALL allow hits on other valid ways during FILL without updating ages.
REQ-028 SHALL update ages on every IDLE cycle with a hit on way w, and on refill completion for the victim: ages below age[w] increment, age[w] becomes 0, others unchanged, so ages remain a permutation of 0..WAYS-1.
REQ-029 SHALL advance the round-robin pointer modulo WAYS on each refill completion that used the pointer.
REQ-030 SHALL, when invalidate_i is asserted, on the next edge clear all valid bits, abort any FILL to IDLE, reset ages to age[i]=i and pointer to 0; invalidate_i takes priority over simultaneous grant, hit or completion.
REQ-031 SHALL leave all state unchanged while active_set_i is 0, except for invalidate_i.

Reset
REQ-032 SHALL, while reset_i is high, force valid=0, age[i]=i, pointer=0, state IDLE, count 0, refill_done_o=0; outputs then read cache_set_miss_o=1, data_o=0, hit_way_o=0, refill_busy_o=0; reset mid-FILL discards the partial line.

Verification
REQ-033 SHALL cover the following case (defaults): reset, then active, tag 500, grant for 8 beats -> miss for 8 cycles, then hit, data_o = beat0[31:0], and refill_done_o pulses once.
REQ-034 SHALL cover the following case: fill ways with tags 500/600/700/800 in order -> ages {3,2,1,0}, and reading tags 800..500 gives ages {0,1,2,3} with correct words at offsets 4..16.
REQ-035 SHALL cover the following case: active_set_i=0, grant=1, varying tags for 64 cycles -> miss=1 each cycle and ages unchanged.
REQ-036 SHALL cover the following case: with all ways valid, ages {0,1,2,3}, and a refill of tag 1000 -> victim is way 3, ages become {1,2,3,0}, and a subsequent hit on way 1 gives {2,0,3,1}.
REQ-037 SHALL cover the following case: grant dropped for 3 cycles mid-fill -> count holds, and completion occurs 3 cycles later.
REQ-038 SHALL cover the following case: invalidate_i at beat 4, and separately reset_i asserted mid-FILL -> all misses, refill_busy_o=0, ages {0,1,2,3}, and REPL_MODE=1 victims cycle 0,1,2,3,0.

Source files
------------

// File: rtl/cache_set_nway.sv
// One set of an N-way set-associative cache: tag lookup with word read-out,
// beat-wise line refill FSM and LRU-age or round-robin victim selection.
module cache_set_nway #(
    parameter int BLOCK_BYTES = 64,
    parameter int WAYS        = 4,
    parameter int TAG_BITS    = 26,
    parameter int REFILL_W    = 64,
    parameter int REPL_MODE   = 0
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           active_set_i,
    input  logic                           repl_grant_i,
    input  logic                           invalidate_i,
    input  logic [$clog2(BLOCK_BYTES)-1:0] block_i,
    input  logic [TAG_BITS-1:0]            tag_i,
    input  logic [REFILL_W-1:0]            rep_word_i,
    output logic [31:0]                    data_o,
    output logic                           cache_set_miss_o,
    output logic [$clog2(WAYS)-1:0]        hit_way_o,
    output logic                           refill_busy_o,
    output logic                           refill_done_o
);
    localparam int OFF_W  = $clog2(BLOCK_BYTES);
    localparam int WAY_W  = $clog2(WAYS);
    localparam int LINE_W = BLOCK_BYTES * 8;
    localparam int BEATS  = LINE_W / REFILL_W;
    localparam int CNT_W  = $clog2(BEATS) + 1;

    typedef enum logic {IDLE, FILL} state_t;

    state_t                           state_q, state_d;
    logic [CNT_W-1:0]                 cnt_q, cnt_d;
    logic [WAY_W-1:0]                 victim_q, victim_d;
    logic                             rr_used_q, rr_used_d;
    logic [WAYS-1:0]                  valid_q, valid_d;
    logic [WAYS-1:0][WAY_W-1:0]       age_q, age_d;
    logic [WAY_W-1:0]                 rr_q, rr_d;
    logic                             done_q, done_d;
    logic [WAYS-1:0][TAG_BITS-1:0]    tag_q, tag_d;
    logic [WAYS-1:0][LINE_W-1:0]      line_q, line_d;

    logic                             hit_c;
    logic [WAY_W-1:0]                 hit_way_c;
    logic [WAY_W-1:0]                 victim_c;
    logic                             have_inv_c;
    logic                             use_rr_c;
    logic                             wr_en;
    logic [WAY_W-1:0]                 wr_way;
    logic [CNT_W-1:0]                 wr_beat;
    logic                             complete;
    logic [OFF_W-1:0]                 word_idx;

    function automatic logic [WAYS-1:0][WAY_W-1:0] age_init();
        logic [WAYS-1:0][WAY_W-1:0] r;
        for (int i = 0; i < WAYS; i++) r[i] = WAY_W'(i);
        return r;
    endfunction

    // Most-recent way goes to age 0; only younger ways age by one.
    function automatic logic [WAYS-1:0][WAY_W-1:0] touch(
        input logic [WAYS-1:0][WAY_W-1:0] a,
        input logic [WAY_W-1:0]           w
    );
        logic [WAYS-1:0][WAY_W-1:0] r;
        r = a;
        for (int i = 0; i < WAYS; i++) begin
            if (WAY_W'(i) == w) r[i] = '0;
            else if (a[i] < a[w]) r[i] = a[i] + WAY_W'(1);
        end
        return r;
    endfunction

    always_comb begin
        hit_c     = 1'b0;
        hit_way_c = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (active_set_i && valid_q[w] && tag_q[w] == tag_i) begin
                hit_c     = 1'b1;
                hit_way_c = WAY_W'(w);
            end
        end
    end

    always_comb begin
        victim_c   = '0;
        have_inv_c = 1'b0;
        use_rr_c   = 1'b0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[w]) begin
                victim_c   = WAY_W'(w);
                have_inv_c = 1'b1;
            end
        end
        if (!have_inv_c) begin
            if (REPL_MODE == 1) begin
                victim_c = rr_q;
                use_rr_c = 1'b1;
            end else begin
                for (int w = 0; w < WAYS; w++) begin
                    if (age_q[w] == WAY_W'(WAYS - 1)) victim_c = WAY_W'(w);
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        victim_d  = victim_q;
        rr_used_d = rr_used_q;
        valid_d   = valid_q;
        age_d     = age_q;
        rr_d      = rr_q;
        done_d    = 1'b0;
        tag_d     = tag_q;
        line_d    = line_q;
        wr_en     = 1'b0;
        wr_way    = victim_q;
        wr_beat   = cnt_q;
        complete  = 1'b0;

        case (state_q)
            IDLE: begin
                if (active_set_i && !hit_c && repl_grant_i) begin
                    // The victim stays invalid until its last beat lands.
                    wr_en            = 1'b1;
                    wr_way           = victim_c;
                    wr_beat          = '0;
                    victim_d         = victim_c;
                    rr_used_d        = use_rr_c;
                    tag_d[victim_c]  = tag_i;
                    valid_d[victim_c] = 1'b0;
                    if (BEATS == 1) begin
                        complete = 1'b1;
                    end else begin
                        state_d = FILL;
                        cnt_d   = CNT_W'(1);
                    end
                end else if (active_set_i && hit_c) begin
                    age_d = touch(age_q, hit_way_c);
                end
            end
            FILL: begin
                if (active_set_i && repl_grant_i) begin
                    wr_en = 1'b1;
                    if (cnt_q == CNT_W'(BEATS - 1)) complete = 1'b1;
                    else cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (wr_en) line_d[wr_way][int'(wr_beat) * REFILL_W +: REFILL_W] = rep_word_i;

        if (complete) begin
            valid_d[wr_way] = 1'b1;
            age_d           = touch(age_q, wr_way);
            if (rr_used_d) rr_d = rr_q + WAY_W'(1);
            state_d = IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
        end

        if (invalidate_i) begin
            valid_d = '0;
            state_d = IDLE;
            cnt_d   = '0;
            age_d   = age_init();
            rr_d    = '0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            victim_q  <= '0;
            rr_used_q <= 1'b0;
            valid_q   <= '0;
            age_q     <= age_init();
            rr_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            victim_q  <= victim_d;
            rr_used_q <= rr_used_d;
            valid_q   <= valid_d;
            age_q     <= age_d;
            rr_q      <= rr_d;
            done_q    <= done_d;
        end
    end

    // Tag and line storage is qualified by valid_q, so it needs no reset.
    always_ff @(posedge clk_i) begin
        tag_q  <= tag_d;
        line_q <= line_d;
    end

    assign word_idx         = block_i >> 2;
    assign data_o           = hit_c ? line_q[hit_way_c][int'(word_idx) * 32 +: 32] : 32'd0;
    assign cache_set_miss_o = !hit_c;
    assign hit_way_o        = hit_way_c;
    assign refill_busy_o    = (state_q == FILL);
    assign refill_done_o    = done_q;
endmodule

// File: tb/tb_cache_set_nway.sv
// Directed bench for cache_set_nway: LRU instance checked throughout, a
// round-robin instance checked for victim order at the end.
module tb_cache_set_nway;
    logic        clk = 1'b0;
    logic        reset_i;
    logic        active_set_i;
    logic        repl_grant_i;
    logic        invalidate_i;
    logic [5:0]  block_i;
    logic [25:0] tag_i;
    logic [63:0] rep_word_i;
    logic [31:0] data_o, rr_data_o;
    logic        miss_o, rr_miss_o;
    logic [1:0]  hit_way_o, rr_hit_way_o;
    logic        busy_o, rr_busy_o;
    logic        done_o, rr_done_o;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cache_set_nway #(.REPL_MODE(0)) dut (
        .clk_i(clk), .reset_i(reset_i), .active_set_i(active_set_i),
        .repl_grant_i(repl_grant_i), .invalidate_i(invalidate_i),
        .block_i(block_i), .tag_i(tag_i), .rep_word_i(rep_word_i),
        .data_o(data_o), .cache_set_miss_o(miss_o), .hit_way_o(hit_way_o),
        .refill_busy_o(busy_o), .refill_done_o(done_o)
    );

    cache_set_nway #(.REPL_MODE(1)) dut_rr (
        .clk_i(clk), .reset_i(reset_i), .active_set_i(active_set_i),
        .repl_grant_i(repl_grant_i), .invalidate_i(invalidate_i),
        .block_i(block_i), .tag_i(tag_i), .rep_word_i(rep_word_i),
        .data_o(rr_data_o), .cache_set_miss_o(rr_miss_o), .hit_way_o(rr_hit_way_o),
        .refill_busy_o(rr_busy_o), .refill_done_o(rr_done_o)
    );

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] beat_word(input int tag, input int n);
        logic [15:0] t;
        logic [7:0]  b;
        t = tag[15:0];
        b = n[7:0];
        return {t, b, 8'hB1, t, b, 8'hA0};
    endfunction

    function automatic logic [31:0] exp_word(input int tag, input int off);
        int k;
        logic [15:0] t;
        logic [7:0]  b;
        k = off >> 2;
        t = tag[15:0];
        b = 8'(k >> 1);
        return (k % 2 == 1) ? {t, b, 8'hB1} : {t, b, 8'hA0};
    endfunction

    task automatic chk_ages(input string name, input int a0, input int a1, input int a2, input int a3);
        logic [7:0] e;
        e = {2'(a3), 2'(a2), 2'(a1), 2'(a0)};
        chk(name, 64'(dut.age_q), 64'(e));
    endtask

    // Eight granted beats; returns in the cycle after the final beat is written.
    task automatic do_fill(input int tag, input bit check_fill);
        active_set_i = 1'b1;
        tag_i        = 26'(tag);
        repl_grant_i = 1'b1;
        for (int n = 0; n < 8; n++) begin
            rep_word_i = beat_word(tag, n);
            if (check_fill) begin
                #1;
                chk("fill_miss", 64'(miss_o), 64'd1);
                chk("fill_done_low", 64'(done_o), 64'd0);
                if (n > 0) chk("fill_busy", 64'(busy_o), 64'd1);
            end
            tick();
        end
        repl_grant_i = 1'b0;
    endtask

    task automatic read(input string name, input int tag, input int off, input int way);
        active_set_i = 1'b1;
        repl_grant_i = 1'b0;
        tag_i        = 26'(tag);
        block_i      = 6'(off);
        #1;
        chk({name, "_miss"}, 64'(miss_o), 64'd0);
        chk({name, "_way"}, 64'(hit_way_o), 64'(way));
        chk({name, "_data"}, 64'(data_o), 64'(exp_word(tag, off)));
        tick();
        active_set_i = 1'b0;
    endtask

    task automatic probe_miss(input string name, input int tag);
        active_set_i = 1'b1;
        repl_grant_i = 1'b0;
        tag_i        = 26'(tag);
        #1;
        chk(name, 64'(miss_o), 64'd1);
        chk({name, "_data"}, 64'(data_o), 64'd0);
        active_set_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_i      = 1'b1;
        active_set_i = 1'b0;
        repl_grant_i = 1'b0;
        invalidate_i = 1'b0;
        block_i      = '0;
        tag_i        = '0;
        rep_word_i   = '0;
        tick();
        tick();
        chk("rst_miss", 64'(miss_o), 64'd1);
        chk("rst_data", 64'(data_o), 64'd0);
        chk("rst_way", 64'(hit_way_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk_ages("rst_ages", 0, 1, 2, 3);
        reset_i = 1'b0;
        tick();

        // First refill: miss for all eight beat cycles, then hit on way 0.
        block_i = 6'd0;
        do_fill(500, 1'b1);
        #1;
        chk("f500_done", 64'(done_o), 64'd1);
        chk("f500_miss", 64'(miss_o), 64'd0);
        chk("f500_way", 64'(hit_way_o), 64'd0);
        chk("f500_data", 64'(data_o), 64'(beat_word(500, 0) & 64'hFFFF_FFFF));
        active_set_i = 1'b0;
        tick();
        chk("f500_done_pulse", 64'(done_o), 64'd0);

        do_fill(600, 1'b0);
        do_fill(700, 1'b0);
        do_fill(800, 1'b0);
        active_set_i = 1'b0;
        #1;
        chk_ages("fill4_ages", 3, 2, 1, 0);
        tick();

        read("rd800", 800, 4, 3);
        chk_ages("rd800_ages", 3, 2, 1, 0);
        read("rd700", 700, 8, 2);
        chk_ages("rd700_ages", 3, 2, 0, 1);
        read("rd600", 600, 12, 1);
        chk_ages("rd600_ages", 3, 0, 1, 2);
        read("rd500", 500, 16, 0);
        chk_ages("rd500_ages", 0, 1, 2, 3);

        // Inactive set: grant and matching tags must change nothing.
        active_set_i = 1'b0;
        repl_grant_i = 1'b1;
        for (int i = 0; i < 64; i++) begin
            tag_i      = 26'(500 + (i % 4) * 100);
            rep_word_i = {$urandom(), $urandom()};
            #1;
            chk("inact_miss", 64'(miss_o), 64'd1);
            tick();
        end
        repl_grant_i = 1'b0;
        chk_ages("inact_ages", 0, 1, 2, 3);
        chk("inact_busy", 64'(busy_o), 64'd0);

        // LRU eviction of the oldest way.
        do_fill(1000, 1'b0);
        #1;
        chk("f1000_way", 64'(hit_way_o), 64'd3);
        chk_ages("f1000_ages", 1, 2, 3, 0);
        active_set_i = 1'b0;
        tick();
        probe_miss("evicted800", 800);
        tick();
        read("rd600b", 600, 12, 1);
        chk_ages("rd600b_ages", 2, 0, 3, 1);

        // Stalled refill with hits on another way and tag changes mid-fill.
        active_set_i = 1'b1;
        tag_i        = 26'd1100;
        repl_grant_i = 1'b1;
        for (int n = 0; n < 4; n++) begin
            rep_word_i = beat_word(1100, n);
            tick();
        end
        repl_grant_i = 1'b0;
        tag_i        = 26'd600;
        block_i      = 6'd12;
        for (int s = 0; s < 3; s++) begin
            #1;
            chk("stall_busy", 64'(busy_o), 64'd1);
            chk("stall_cnt", 64'(dut.cnt_q), 64'd4);
            chk("stall_hit_other", 64'(hit_way_o), 64'd1);
            chk("stall_done", 64'(done_o), 64'd0);
            tick();
        end
        chk_ages("stall_ages", 2, 0, 3, 1);
        tag_i        = 26'd999;
        repl_grant_i = 1'b1;
        for (int n = 4; n < 8; n++) begin
            rep_word_i = beat_word(1100, n);
            #1;
            chk("stall2_busy", 64'(busy_o), 64'd1);
            tick();
        end
        repl_grant_i = 1'b0;
        tag_i        = 26'd1100;
        block_i      = 6'd60;
        #1;
        chk("stall_done_end", 64'(done_o), 64'd1);
        chk("stall_way", 64'(hit_way_o), 64'd2);
        chk("stall_data", 64'(data_o), 64'(exp_word(1100, 60)));
        chk_ages("stall_end_ages", 3, 1, 0, 2);
        active_set_i = 1'b0;
        tick();

        // Invalidate at beat 4 overrides the in-progress refill.
        active_set_i = 1'b1;
        tag_i        = 26'd1200;
        repl_grant_i = 1'b1;
        for (int n = 0; n < 4; n++) begin
            rep_word_i = beat_word(1200, n);
            tick();
        end
        rep_word_i   = beat_word(1200, 4);
        invalidate_i = 1'b1;
        tick();
        invalidate_i = 1'b0;
        repl_grant_i = 1'b0;
        #1;
        chk("inv_busy", 64'(busy_o), 64'd0);
        chk("inv_cnt", 64'(dut.cnt_q), 64'd0);
        chk_ages("inv_ages", 0, 1, 2, 3);
        probe_miss("inv_miss600", 600);
        probe_miss("inv_miss1100", 1100);
        probe_miss("inv_miss1200", 1200);
        tick();
        chk("inv_done", 64'(done_o), 64'd0);

        // Reset in the middle of a refill.
        active_set_i = 1'b1;
        tag_i        = 26'd1300;
        repl_grant_i = 1'b1;
        for (int n = 0; n < 3; n++) begin
            rep_word_i = beat_word(1300, n);
            tick();
        end
        reset_i = 1'b1;
        #1;
        chk("rstfill_busy", 64'(busy_o), 64'd0);
        chk("rstfill_miss", 64'(miss_o), 64'd1);
        chk("rstfill_done", 64'(done_o), 64'd0);
        chk_ages("rstfill_ages", 0, 1, 2, 3);
        tick();
        repl_grant_i = 1'b0;
        active_set_i = 1'b0;
        reset_i      = 1'b0;
        tick();
        probe_miss("rstfill_miss1300", 1300);
        tick();

        // Round-robin instance: invalid ways first, then pointer order.
        for (int i = 0; i < 9; i++) begin
            do_fill(2000 + i * 100, 1'b0);
            #1;
            chk("rr_miss", 64'(rr_miss_o), 64'd0);
            chk("rr_victim", 64'(rr_hit_way_o), 64'(i % 4));
            active_set_i = 1'b0;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
